// File: rtl/noc_pkg.sv
// Shared constants and types for the NoC master arbiter.
// Holds the processing-unit count, beat layout, id width and FSM state type.
package noc_pkg;

  localparam int unsigned N_PROC    = 4;
  localparam int unsigned DATA_W    = 9;
  localparam int unsigned ID_W      = 2;
  localparam int unsigned TLAST_BIT = 8;
  localparam int unsigned CNT_W     = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches the request vector starting
// one position after the pointer, wrapping modulo N_PROC.
// Ports:
//   i_req      - per-source request bits
//   i_ptr      - id of the most recent winner
//   o_winner_c - id of the selected source (0 when none)
//   o_valid_c  - high when any request is asserted
module rr_arbiter
  import noc_pkg::*;
(
  input  logic [N_PROC-1:0] i_req,
  input  logic [ID_W-1:0]   i_ptr,
  output logic [ID_W-1:0]   o_winner_c,
  output logic              o_valid_c
);

  // First requester found after the pointer wins
  always_comb begin
    logic [ID_W-1:0] idx;
    idx        = '0;
    o_winner_c = '0;
    o_valid_c  = 1'b0;
    for (int unsigned k = 1; k <= N_PROC; k++) begin
      idx = ID_W'(32'(i_ptr) + k);
      if (!o_valid_c && i_req[idx]) begin
        o_winner_c = idx;
        o_valid_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_master_arbiter.sv
// Single-owner NoC crossbar master: round-robin grants one source at a time,
// forwards its beats to the chosen destination until tlast or timeout.
// Ports:
//   clock, reset        - clock, synchronous active-high reset
//   request_transfer_i  - per-source request
//   which_processor_i   - per-source destination id, 2 bits each
//   data_in             - per-source beat, DATA_W bits each (MSB = tlast)
//   master_response     - one-hot grant pulse to the winning source
//   data_out/data_valid - per-destination beat and valid
//   busy                - high whenever not IDLE
//   grant_src/grant_dst - current owner/target, 0 in IDLE
//   route_err           - pulse on a rejected self-addressed request
//   timeout_err         - pulse on a stream abort without tlast
module noc_master_arbiter #(
  parameter int unsigned N_PROC  = 4,
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned TIMEOUT = 300
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_PROC-1:0]        request_transfer_i,
  input  logic [2*N_PROC-1:0]      which_processor_i,
  input  logic [N_PROC*DATA_W-1:0] data_in,
  output logic [N_PROC-1:0]        master_response,
  output logic [N_PROC*DATA_W-1:0] data_out,
  output logic [N_PROC-1:0]        data_valid,
  output logic                     busy,
  output logic [1:0]               grant_src,
  output logic [1:0]               grant_dst,
  output logic                     route_err,
  output logic                     timeout_err
);

  import noc_pkg::*;

  state_e                   r_state, w_state_nx;
  logic [ID_W-1:0]          r_rr_ptr, w_ptr_nx;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nx;
  logic                     r_drain, w_drain_nx;
  logic [ID_W-1:0]          w_src_nx, w_dst_nx;
  logic [N_PROC-1:0]        w_resp_nx, w_dv_nx;
  logic [N_PROC*DATA_W-1:0] w_dout_nx;
  logic                     w_busy_nx, w_rerr_nx, w_terr_nx;
  logic [ID_W-1:0]          w_win, w_win_dst;
  logic                     w_win_valid;
  logic [DATA_W-1:0]        w_beat;

  rr_arbiter u_rr_arbiter (
    .i_req      (request_transfer_i),
    .i_ptr      (r_rr_ptr),
    .o_winner_c (w_win),
    .o_valid_c  (w_win_valid)
  );

  assign w_win_dst = which_processor_i[ID_W*32'(w_win) +: ID_W];
  assign w_beat    = data_in[DATA_W*32'(grant_src) +: DATA_W];

  // Next-state and next-output logic
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_rr_ptr;
    w_cnt_nx   = r_cnt;
    w_drain_nx = r_drain;
    w_src_nx   = grant_src;
    w_dst_nx   = grant_dst;
    w_resp_nx  = '0;
    w_dv_nx    = '0;
    w_dout_nx  = '0;
    w_rerr_nx  = 1'b0;
    w_terr_nx  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nx   = '0;
        w_drain_nx = 1'b0;
        if (w_win_valid) begin
          // Pointer moves to the winner even when its route is rejected
          w_ptr_nx = w_win;
          if (w_win_dst == w_win) begin
            w_rerr_nx = 1'b1;
          end else begin
            w_state_nx       = ST_GRANT;
            w_src_nx         = w_win;
            w_dst_nx         = w_win_dst;
            w_resp_nx[w_win] = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        w_state_nx = ST_STREAM;
        w_cnt_nx   = r_cnt + CNT_W'(1);
      end
      ST_STREAM: begin
        // Counter counts cycles since GRANT; abort lands TIMEOUT cycles after it
        w_cnt_nx = r_cnt + CNT_W'(1);
        w_dout_nx[DATA_W*32'(grant_dst) +: DATA_W] = w_beat;
        w_dv_nx[grant_dst] = 1'b1;
        if (w_beat[TLAST_BIT]) begin
          w_state_nx = ST_DRAIN;
          w_drain_nx = 1'b0;
        end else if (w_cnt_nx == CNT_W'(TIMEOUT)) begin
          w_state_nx = ST_IDLE;
          w_terr_nx  = 1'b1;
          w_dout_nx  = '0;
          w_dv_nx    = '0;
          w_src_nx   = '0;
          w_dst_nx   = '0;
          w_cnt_nx   = '0;
        end
      end
      ST_DRAIN: begin
        // Two-cycle hold: r_drain marks the second cycle
        w_drain_nx = 1'b1;
        if (r_drain) begin
          w_state_nx = ST_IDLE;
          w_drain_nx = 1'b0;
          w_src_nx   = '0;
          w_dst_nx   = '0;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase

    w_busy_nx = (w_state_nx != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_rr_ptr        <= ID_W'(N_PROC - 1);
      r_cnt           <= '0;
      r_drain         <= 1'b0;
      grant_src       <= '0;
      grant_dst       <= '0;
      master_response <= '0;
      data_out        <= '0;
      data_valid      <= '0;
      busy            <= 1'b0;
      route_err       <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      r_state         <= w_state_nx;
      r_rr_ptr        <= w_ptr_nx;
      r_cnt           <= w_cnt_nx;
      r_drain         <= w_drain_nx;
      grant_src       <= w_src_nx;
      grant_dst       <= w_dst_nx;
      master_response <= w_resp_nx;
      data_out        <= w_dout_nx;
      data_valid      <= w_dv_nx;
      busy            <= w_busy_nx;
      route_err       <= w_rerr_nx;
      timeout_err     <= w_terr_nx;
    end
  end

endmodule

// File: tb/tb_noc_master_arbiter.sv
// Self-checking bench for noc_master_arbiter: a grant-record model predicts
// every output each cycle; directed scenarios add hand-computed literals.
`timescale 1ns/1ps
module tb_noc_master_arbiter;

  localparam int TIMEOUT = 300;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  request_transfer_i;
  logic [7:0]  which_processor_i;
  logic [35:0] data_in;
  logic [3:0]  master_response;
  logic [35:0] data_out;
  logic [3:0]  data_valid;
  logic        busy;
  logic [1:0]  grant_src, grant_dst;
  logic        route_err, timeout_err;

  int checks = 0;
  int errors = 0;

  noc_master_arbiter #(.N_PROC(4), .DATA_W(9), .TIMEOUT(TIMEOUT)) dut (
    .clock              (clock),
    .reset              (reset),
    .request_transfer_i (request_transfer_i),
    .which_processor_i  (which_processor_i),
    .data_in            (data_in),
    .master_response    (master_response),
    .data_out           (data_out),
    .data_valid         (data_valid),
    .busy               (busy),
    .grant_src          (grant_src),
    .grant_dst          (grant_dst),
    .route_err          (route_err),
    .timeout_err        (timeout_err)
  );

  always #5 clock = ~clock;

  // ---------------- model: grant record + phase of the current transfer
  localparam int P_IDLE = 0, P_GRANT = 1, P_STREAM = 2, P_DRAIN = 3;
  int m_phase, m_ptr, m_src, m_dst, m_scyc, m_drain;
  logic [3:0]  e_resp, e_dv;
  logic [35:0] e_dout;
  logic        e_busy, e_rerr, e_terr;
  logic [1:0]  e_gs, e_gd;
  bit          chk_en = 1'b0;

  always @(posedge clock) begin
    logic [8:0] beat;
    int w, d;
    if (reset) begin
      m_phase = P_IDLE; m_ptr = 3; m_src = 0; m_dst = 0; m_scyc = 0; m_drain = 0;
      e_resp = '0; e_dout = '0; e_dv = '0; e_busy = 0; e_gs = 0; e_gd = 0;
      e_rerr = 0; e_terr = 0;
      chk_en = 1'b1;
    end else begin
      e_resp = '0; e_rerr = 0; e_terr = 0; e_dv = '0; e_dout = '0;
      case (m_phase)
        P_IDLE: begin
          w = -1;
          for (int k = 1; k <= 4; k++)
            if (w < 0 && request_transfer_i[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
          if (w >= 0) begin
            d = int'(which_processor_i[2*w +: 2]);
            m_ptr = w;
            if (d == w) e_rerr = 1;
            else begin
              m_phase = P_GRANT; m_src = w; m_dst = d;
              e_resp[w] = 1'b1; e_busy = 1; e_gs = 2'(w); e_gd = 2'(d);
            end
          end
        end
        P_GRANT: begin m_phase = P_STREAM; m_scyc = 0; end
        P_STREAM: begin
          beat = data_in[9*m_src +: 9];
          m_scyc++;
          if (beat[8]) begin
            e_dout[9*m_dst +: 9] = beat; e_dv[m_dst] = 1'b1;
            m_phase = P_DRAIN; m_drain = 2;
          end else if (m_scyc == TIMEOUT - 1) begin
            // abort becomes visible exactly TIMEOUT cycles after GRANT
            e_terr = 1; m_phase = P_IDLE; e_busy = 0; e_gs = 0; e_gd = 0;
          end else begin
            e_dout[9*m_dst +: 9] = beat; e_dv[m_dst] = 1'b1;
          end
        end
        default: begin
          m_drain--;
          if (m_drain == 0) begin m_phase = P_IDLE; e_busy = 0; e_gs = 0; e_gd = 0; end
        end
      endcase
    end
  end

  // ---------------- per-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      checks++;
      if ({master_response, data_out, data_valid, busy, grant_src, grant_dst, route_err, timeout_err}
          !== {e_resp, e_dout, e_dv, e_busy, e_gs, e_gd, e_rerr, e_terr}) begin
        errors++;
        $display("FAIL cycle_model t=%0t act/exp resp %h/%h dout %h/%h dv %h/%h busy %b/%b gs %0d/%0d gd %0d/%0d rerr %b/%b terr %b/%b",
                 $time, master_response, e_resp, data_out, e_dout, data_valid, e_dv,
                 busy, e_busy, grant_src, e_gs, grant_dst, e_gd, route_err, e_rerr, timeout_err, e_terr);
      end
    end
  end

  // ---------------- helpers
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_grant(input logic [3:0] exp, input string nm);
    int n = 0;
    while (master_response == 4'b0 && n < 40) begin tick(); n++; end
    chk(nm, master_response, exp);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin tick(); n++; end
    chk(nm, busy, 0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_resp"}, master_response, 0);
    chk({nm, "_dout"}, data_out, 0);
    chk({nm, "_dv"},   data_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_gs"},   grant_src, 0);
    chk({nm, "_gd"},   grant_dst, 0);
    chk({nm, "_errs"}, {route_err, timeout_err}, 0);
  endtask

  // ---------------- directed scenarios
  initial begin
    int n;
    reset = 1'b1; request_transfer_i = '0; which_processor_i = '0; data_in = '0;
    repeat (2) tick();
    chk_reset_vals("rst");

    // sources 0 and 2 compete: 0 first, 2 after 0's drain
    reset = 1'b0;
    request_transfer_i = 4'b0101;
    which_processor_i  = 8'h31;            // src0->1, src2->3
    tick();
    chk("pair_resp0", master_response, 4'b0001);
    chk("pair_gsrc0", grant_src, 0);
    chk("pair_gdst0", grant_dst, 1);
    chk("pair_busy0", busy, 1);
    request_transfer_i = 4'b0100;
    data_in[8:0] = 9'h1AA;                 // single beat with tlast
    tick();                                // STREAM
    tick();                                // DRAIN 1: beat visible
    chk("pair_beat0", data_out[17:9], 9'h1AA);
    chk("pair_dv0", data_valid, 4'b0010);
    data_in[26:18] = 9'h155;
    wait_grant(4'b0100, "pair_resp2");
    chk("pair_gsrc2", grant_src, 2);
    chk("pair_gdst2", grant_dst, 3);
    request_transfer_i = 4'b0000;
    wait_idle("pair_idle");
    data_in = '0;

    // source 1 -> dest 2, four beats
    which_processor_i = 8'h08;
    data_in[17:9] = 9'h0FF;                // junk during GRANT must not be forwarded
    request_transfer_i = 4'b0010;
    wait_grant(4'b0010, "len4_resp");
    request_transfer_i = 4'b0000;
    tick(); data_in[17:9] = 9'h001;        // STREAM 1
    tick(); chk("len4_b1", data_out[26:18], 9'h001); chk("len4_dv1", data_valid, 4'b0100);
    data_in[17:9] = 9'h002;
    tick(); chk("len4_b2", data_out[26:18], 9'h002);
    data_in[17:9] = 9'h003;
    tick(); chk("len4_b3", data_out[26:18], 9'h003);
    data_in[17:9] = 9'h104;
    tick(); chk("len4_b4", data_out[26:18], 9'h104); chk("len4_dv4", data_valid, 4'b0100);
    tick(); chk("len4_d2_dv", data_valid, 0); chk("len4_d2_busy", busy, 1);
    tick(); chk("len4_idle_busy", busy, 0); chk("len4_idle_gs", grant_src, 0);
    data_in = '0;

    // self-addressed request from source 3
    which_processor_i = 8'hC0;
    request_transfer_i = 4'b1000;
    tick();
    chk("self_rerr", route_err, 1);
    chk("self_resp", master_response, 0);
    chk("self_busy", busy, 0);
    request_transfer_i = 4'b0000;
    tick();
    chk("self_rerr_clr", route_err, 0);
    chk("self_busy2", busy, 0);

    // source 0 streams without tlast
    which_processor_i = 8'h02;
    data_in[8:0] = 9'h055;
    request_transfer_i = 4'b0001;
    wait_grant(4'b0001, "to_resp");
    request_transfer_i = 4'b0000;
    n = 0;
    while (timeout_err !== 1'b1 && n < 400) begin tick(); n++; end
    chk("to_cycles", n, TIMEOUT);
    chk("to_busy", busy, 0);
    chk("to_dv", data_valid, 0);
    tick();
    chk("to_pulse_clr", timeout_err, 0);
    data_in = '0;

    // fresh reset, all four request single-beat bursts
    reset = 1'b1;
    tick(); tick();
    chk_reset_vals("rst2");
    reset = 1'b0;
    which_processor_i = 8'h39;             // i -> (i+1)%4
    data_in = {9'h104, 9'h103, 9'h102, 9'h101};
    request_transfer_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(4'b0001 << (i % 4), "rr_resp");
      chk("rr_gsrc", grant_src, i % 4);
      tick();
      tick();
      chk("rr_dv", data_valid, 4'b0001 << ((i + 1) % 4));
    end
    request_transfer_i = 4'b0000;
    wait_idle("rr_idle");
    data_in = '0;

    // reset in the middle of a stream
    which_processor_i = 8'h08;
    request_transfer_i = 4'b0010;
    wait_grant(4'b0010, "mid_resp");
    request_transfer_i = 4'b0000;
    tick(); data_in[17:9] = 9'h011;
    tick(); data_in[17:9] = 9'h012;
    tick(); data_in[17:9] = 9'h013;
    reset = 1'b1;
    tick();
    chk_reset_vals("mid_rst");
    reset = 1'b0;
    tick();
    chk_reset_vals("mid_after");

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
